// File: rtl/fixedpoint_pkg.sv
// Shared constants and state encoding for the fixed-point averaging stages.
package fixedpoint_pkg;

  localparam int DATA_W = 8;
  localparam int LOG2_N = 2;
  localparam int SUM_W  = DATA_W + LOG2_N;
  localparam int N      = 1 << LOG2_N;
  localparam int CNT_W  = LOG2_N + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/fixedpoint_avg4_if.sv
// Sample-in / average-out bus of the sliding-window averager.
interface fixedpoint_avg4_if;
  import fixedpoint_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              clear;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SUM_W-1:0]  out_sum;
  logic              full;

  // Producer side: drives samples and flush, observes results.
  modport master (
    output in_valid, in_data, clear,
    input  out_valid, out_data, out_sum, full
  );

  // Averager side.
  modport slave (
    input  in_valid, in_data, clear,
    output out_valid, out_data, out_sum, full
  );

endinterface

// File: rtl/fixedpoint_round_shift.sv
// Round-half-up right shift by LOG2_N, SUM_W -> DATA_W.
// One extra headroom bit keeps the +half from wrapping; the result saturates
// so the block stays safe if reused with sums that are not window-bounded.
module fixedpoint_round_shift
  import fixedpoint_pkg::*;
(
  input  logic [SUM_W-1:0]  sum_i,
  output logic [DATA_W-1:0] avg_o
);

  logic [SUM_W:0] biased;
  logic [SUM_W:0] shifted;

  assign biased  = {1'b0, sum_i} + (SUM_W+1)'(1 << (LOG2_N - 1));
  assign shifted = biased >> LOG2_N;

  // Clamp to all-ones if anything spilled above DATA_W.
  always_comb begin
    avg_o = shifted[DATA_W-1:0];
    if (|shifted[SUM_W:DATA_W]) avg_o = '1;
  end

endmodule

// File: rtl/fixedpoint_avg4.sv
// Sliding-window sum/average over the last N scaled samples.
// Circular buffer + running sum; outputs are registered and strobe once the
// window is full. clear flushes synchronously and beats in_valid.
module fixedpoint_avg4
  import fixedpoint_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  fixedpoint_avg4_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LOG2_N-1:0]  wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]  buf_q [N];
  logic [DATA_W-1:0]  buf_d [N];
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [SUM_W-1:0]   out_sum_q, out_sum_d;

  logic [DATA_W-1:0]  oldest;
  logic [SUM_W-1:0]   sum_nxt;
  logic [DATA_W-1:0]  avg_nxt;

  // Sample leaving the window: only present once the window is full.
  assign oldest  = (state_q == RUN) ? buf_q[wr_ptr_q] : '0;
  // Intermediate may wrap past SUM_W; the subtraction brings it back in range.
  assign sum_nxt = sum_q + SUM_W'(bus.in_data) - SUM_W'(oldest);

  fixedpoint_round_shift u_round (
    .sum_i (sum_nxt),
    .avg_o (avg_nxt)
  );

  // Next-state: window update, fill count, FSM and output registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    sum_d       = sum_q;
    buf_d       = buf_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sum_d   = out_sum_q;

    if (bus.clear) begin
      state_d    = EMPTY;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      sum_d      = '0;
      out_data_d = '0;
      out_sum_d  = '0;
    end else if (bus.in_valid) begin
      buf_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d        = wr_ptr_q + LOG2_N'(1);
      sum_d           = sum_nxt;
      cnt_d           = (cnt_q == CNT_W'(N)) ? cnt_q : cnt_q + CNT_W'(1);

      case (state_q)
        EMPTY, FILL: state_d = (cnt_d == CNT_W'(N)) ? RUN : FILL;
        RUN:         state_d = RUN;
        default:     state_d = EMPTY;
      endcase

      if (state_d == RUN) begin
        out_valid_d = 1'b1;
        out_sum_d   = sum_nxt;
        out_data_d  = avg_nxt;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sum_q   <= '0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sum_q   <= out_sum_d;
      for (int i = 0; i < N; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.full      = (state_q == RUN);

endmodule
